// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: word width, FSM encoding,
// and the IF/ID payload bundle.
package if_fetch_stage_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(4);

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instr;
        logic                  valid;
    } ifid_t;

    function automatic logic [WORD_WIDTH-1:0] align_word(input logic [WORD_WIDTH-1:0] a);
        return {a[WORD_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_pc_register.sv
// Fetch program counter: redirect beats advance, otherwise hold.
// Arithmetic wraps modulo 2^WORD_WIDTH.
module pc_register
    import if_fetch_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [WORD_WIDTH-1:0] load_addr,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] pc_plus4
);

    assign pc_plus4 = pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst)
            pc <= '0;
        else if (load)
            pc <= align_word(load_addr);
        else if (advance)
            pc <= pc_plus4;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: request FSM, IF/ID output register, freeze holding slot.
// Optional stall counter port enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_address,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic [WORD_WIDTH-1:0] instruction_out,
    output logic                  valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    logic [1:0]            state, state_next;
    ifid_t                 ifid_q, ifid_d, held_q, held_d, fetched;
    logic [WORD_WIDTH-1:0] pc, pc_plus4, drain_addr;
    logic                  pc_load, pc_adv, drain_load;

    pc_register u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .advance   (pc_adv),
        .load_addr (branch_address),
        .pc        (pc),
        .pc_plus4  (pc_plus4)
    );

    assign fetched  = '{pc: pc_plus4, instr: imem_rdata, valid: 1'b1};
    assign imem_req = (state == ST_FETCH) || (state == ST_DRAIN);
    // While draining, pc already points at the branch target; the bus keeps the old address.
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : pc;

    always_comb begin
        state_next = state;
        ifid_d     = ifid_q;
        held_d     = held_q;
        pc_load    = 1'b0;
        pc_adv     = 1'b0;
        drain_load = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
                if (branch_taken) begin
                    pc_load = 1'b1;
                    ifid_d  = '0;
                end
            end
            ST_FETCH: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    ifid_d  = '0;
                    if (!imem_ack) begin
                        drain_load = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_adv = 1'b1;
                    if (freeze) begin
                        held_d     = fetched;
                        state_next = ST_HOLD;
                    end else begin
                        ifid_d = fetched;
                    end
                end else if (!freeze) begin
                    ifid_d = '0;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_load    = 1'b1;
                    ifid_d     = '0;
                    held_d     = '0;
                    state_next = ST_FETCH;
                end else if (!freeze) begin
                    ifid_d     = held_q;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                // Outstanding request belongs to the abandoned path; its data is dropped.
                if (branch_taken) begin
                    pc_load = 1'b1;
                    ifid_d  = '0;
                end else if (!freeze) begin
                    ifid_d = '0;
                end
                if (imem_ack)
                    state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ifid_q     <= '0;
            held_q     <= '0;
            drain_addr <= '0;
        end else begin
            state  <= state_next;
            ifid_q <= ifid_d;
            held_q <= held_d;
            if (drain_load)
                drain_addr <= pc;
        end
    end

    assign pc_out          = ifid_q.pc;
    assign instruction_out = ifid_q.instr;
    assign valid_out       = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (imem_req && !imem_ack && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal checks, then random
// traffic compared every cycle against a transaction-level fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken, imem_ack;
    logic [31:0] branch_address, imem_rdata;
    logic        imem_req, valid_out;
    logic [31:0] imem_addr, pc_out, instruction_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Model: next fetch address, a one-slot parking spot used while frozen,
    // a "discard next ack" flag with the address still on the bus, and the decode-side view.
    logic        m_ok = 1'b0;
    logic        m_started, m_held_v, m_drain;
    logic [31:0] m_pc, m_drain_a, m_held_p, m_held_i;
    logic [31:0] m_opc, m_oins, m_stall;
    logic        m_ov;
    logic        m_req;
    logic [31:0] m_addr;

    assign m_req  = m_started && !m_held_v;
    assign m_addr = m_drain ? m_drain_a : m_pc;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1; m_started = 1'b0; m_held_v = 1'b0; m_drain = 1'b0;
            m_pc = 0; m_drain_a = 0; m_held_p = 0; m_held_i = 0;
            m_opc = 0; m_oins = 0; m_ov = 1'b0; m_stall = 0;
        end else if (m_ok) begin
            automatic logic req = m_req;
            if (req && !imem_ack && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (branch_taken) begin
                m_opc = 0; m_oins = 0; m_ov = 1'b0; m_held_v = 1'b0;
                if (req && !imem_ack) begin
                    if (!m_drain) m_drain_a = m_pc;
                    m_drain = 1'b1;
                end else begin
                    m_drain = 1'b0;
                end
                m_pc = branch_address & ~32'd3;
            end else if (!m_started) begin
                // first cycle after reset never fetches
            end else if (m_held_v) begin
                if (!freeze) begin
                    m_opc = m_held_p; m_oins = m_held_i; m_ov = 1'b1; m_held_v = 1'b0;
                end
            end else if (m_drain) begin
                if (imem_ack) m_drain = 1'b0;
                if (!freeze) begin m_opc = 0; m_oins = 0; m_ov = 1'b0; end
            end else if (imem_ack) begin
                if (freeze) begin
                    m_held_v = 1'b1; m_held_p = m_pc + 4; m_held_i = imem_rdata;
                end else begin
                    m_opc = m_pc + 4; m_oins = imem_rdata; m_ov = 1'b1;
                end
                m_pc = m_pc + 4;
            end else if (!freeze) begin
                m_opc = 0; m_oins = 0; m_ov = 1'b0;
            end
            m_started = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            chk("imem_req", 32'(imem_req), 32'(m_req));
            chk("imem_addr", imem_addr, m_addr);
            chk("pc_out", pc_out, m_opc);
            chk("instruction_out", instruction_out, m_oins);
            chk("valid_out", 32'(valid_out), 32'(m_ov));
`ifdef IF_PERF_CNT_EN
            chk("stall_cycles", stall_cycles, m_stall);
`endif
        end
    end

    task automatic step(input logic r, input logic f, input logic b,
                        input logic [31:0] ba, input logic a);
        rst = r; freeze = f; branch_taken = b; branch_address = ba; imem_ack = a;
        imem_rdata = a ? (m_addr ^ K) : $urandom;
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst pc_out", pc_out, 0);
        chk("rst valid", 32'(valid_out), 0);
        chk("rst req", 32'(imem_req), 0);
        chk("rst addr", imem_addr, 0);

        // zero-wait stream
        step(0, 0, 0, 0, 1);
        chk("first req", 32'(imem_req), 1);
        chk("first valid", 32'(valid_out), 0);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 1);
            chk("zw pc_out", pc_out, 32'(4 * i));
            chk("zw valid", 32'(valid_out), 1);
            chk("zw instr", instruction_out, 32'(4 * (i - 1)) ^ K);
        end

        // three-cycle wait at 0x10
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("wait addr", imem_addr, 32'h10);
            chk("wait valid", 32'(valid_out), 0);
        end
        step(0, 0, 0, 0, 1);
        chk("wait done pc_out", pc_out, 32'h14);
`ifdef IF_PERF_CNT_EN
        chk("stall count", stall_cycles, 3);
`endif

        // freeze with ack during freeze
        step(0, 1, 0, 0, 1);
        chk("frz hold pc", pc_out, 32'h14);
        chk("frz req", 32'(imem_req), 0);
        step(0, 1, 0, 0, 0);
        chk("frz hold pc2", pc_out, 32'h14);
        step(0, 0, 0, 0, 0);
        chk("unfrz pc_out", pc_out, 32'h18);
        chk("unfrz instr", instruction_out, 32'h14 ^ K);
        chk("unfrz addr", imem_addr, 32'h18);
        step(0, 0, 0, 0, 1);
        chk("after frz pc_out", pc_out, 32'h1C);

        // branch while request at 0x20 is pending
        step(0, 0, 0, 0, 1);
        chk("pre br addr", imem_addr, 32'h20);
        step(0, 0, 1, 32'h100, 0);
        chk("drain valid", 32'(valid_out), 0);
        chk("drain addr", imem_addr, 32'h20);
        step(0, 0, 0, 0, 0);
        chk("drain addr2", imem_addr, 32'h20);
        step(0, 0, 0, 0, 1);
        chk("drained valid", 32'(valid_out), 0);
        chk("target addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 1);
        chk("target pc_out", pc_out, 32'h104);
        chk("target instr", instruction_out, 32'h100 ^ K);

        // branch beats freeze, low bits dropped
        step(0, 1, 1, 32'h43, 1);
        chk("brfrz valid", 32'(valid_out), 0);
        chk("brfrz addr", imem_addr, 32'h40);
        step(0, 0, 0, 0, 1);
        chk("brfrz pc_out", pc_out, 32'h44);

        // wrap at top of address space
        step(0, 0, 1, 32'hFFFF_FFFE, 1);
        chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1);
        chk("wrap pc_out", pc_out, 0);
        chk("wrap valid", 32'(valid_out), 1);

        // reset mid-wait, stale ack afterwards
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("midrst pc_out", pc_out, 0);
        chk("midrst instr", instruction_out, 0);
        chk("midrst addr", imem_addr, 0);
        step(0, 0, 0, 0, 1);
        chk("stale valid", 32'(valid_out), 0);
        chk("stale addr", imem_addr, 0);
        step(0, 0, 0, 0, 1);
        chk("post rst pc_out", pc_out, 4);

        // random traffic; the per-cycle compare process does the checking
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 1) == 1));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
